// File: rtl/dtree_class_debounce.sv
// Debounce filter for the decision-tree classifier: commits a class after HOLD
// identical in-range predictions. Optional err counter via DTREE_DEBOUNCE_ERRCNT_EN.
module dtree_class_debounce #(
   parameter int NCLASS = 10,
   parameter int HOLD   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [3:0] in_class,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [3:0] out_class,
   output logic       overflow,
   output logic [7:0] err_cnt
);

   localparam logic [4:0] NCLASS_C = 5'(NCLASS);
   localparam logic [3:0] HOLD_C   = 4'(HOLD);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_TRACK = 2'd1,
      S_LOCK  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cand;
   logic [3:0] w_cand_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic [3:0] r_last;
   logic       r_last_ok;
   logic       r_out_valid;
   logic [3:0] r_out_class;
   logic       r_overflow;

   logic       w_in_range;
   logic       w_commit;
   logic       w_dup;
   logic       w_slot_free;
   logic       w_emit;
   logic       w_drop;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v >= HOLD_C) ? HOLD_C : v + 4'd1;
   endfunction

   assign w_in_range = ({1'b0, in_class} < NCLASS_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      if (in_valid) begin
         if (!w_in_range) begin
            w_state_nxt = S_EMPTY;
            w_cnt_nxt   = 4'd0;
         end else begin
            case (r_state)
               S_TRACK: begin
                  if (in_class == r_cand) begin
                     w_cnt_nxt = sat_inc(r_cnt);
                  end else begin
                     w_cand_nxt = in_class;
                     w_cnt_nxt  = 4'd1;
                  end
                  w_commit = (w_cnt_nxt == HOLD_C);
               end
               S_LOCK: begin
                  // A repeat of the locked class is not a new streak.
                  if (in_class != r_cand) begin
                     w_cand_nxt  = in_class;
                     w_cnt_nxt   = 4'd1;
                     w_state_nxt = S_TRACK;
                     w_commit    = (HOLD_C == 4'd1);
                  end
               end
               default: begin
                  w_cand_nxt  = in_class;
                  w_cnt_nxt   = 4'd1;
                  w_state_nxt = S_TRACK;
                  w_commit    = (HOLD_C == 4'd1);
               end
            endcase
            if (w_commit) begin
               w_state_nxt = S_LOCK;
            end
         end
      end
   end

   assign w_dup       = r_last_ok && (w_cand_nxt == r_last);
   assign w_slot_free = !r_out_valid || out_ready;
   assign w_emit      = w_commit && !w_dup && w_slot_free;
   assign w_drop      = w_commit && !w_dup && !w_slot_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cand      <= 4'd0;
         r_cnt       <= 4'd0;
         r_last      <= 4'd0;
         r_last_ok   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_class <= 4'd0;
         r_overflow  <= 1'b0;
      end else begin
         r_cand <= w_cand_nxt;
         r_cnt  <= w_cnt_nxt;
         if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_class <= w_cand_nxt;
            r_last      <= w_cand_nxt;
            r_last_ok   <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

`ifdef DTREE_DEBOUNCE_ERRCNT_EN
   logic [7:0] r_err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= 8'd0;
      end else if (in_valid && !w_in_range && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = 8'd0;
`endif

   assign out_valid = r_out_valid;
   assign out_class = r_out_class;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_dtree_class_debounce.sv
// Directed bench for dtree_class_debounce (NCLASS=10, HOLD=3); expected values
// are hand-derived and err_cnt expectations follow DTREE_DEBOUNCE_ERRCNT_EN.
module tb_dtree_class_debounce;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] in_class;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] out_class;
   logic       overflow;
   logic [7:0] err_cnt;

   int n_checks = 0;
   int n_errors = 0;

`ifdef DTREE_DEBOUNCE_ERRCNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   dtree_class_debounce #(.NCLASS(10), .HOLD(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_class  (in_class),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_class (out_class),
      .overflow  (overflow),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] c);
      in_valid = 1'b1;
      in_class = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_class = 4'hF;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check1("rst_out_valid", out_valid, 1'b0);
      check8("rst_out_class", {4'd0, out_class}, 8'd0);
      check1("rst_overflow", overflow, 1'b0);
      check8("rst_err_cnt", err_cnt, 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_class  = 4'd0;
      out_ready = 1'b0;
      idle(2);
      do_reset();

      // 7,7,7 commits after the third sample; a fourth 7 emits nothing
      out_ready = 1'b1;
      send(4'd7);
      send(4'd7);
      check1("t1_no_commit_yet", out_valid, 1'b0);
      send(4'd7);
      check1("t1_valid", out_valid, 1'b1);
      check8("t1_class", {4'd0, out_class}, 8'd7);
      idle(1);
      check1("t1_accepted", out_valid, 1'b0);
      send(4'd7);
      check1("t1_repeat_silent", out_valid, 1'b0);

      // 4,4,2,4,4,4: glitch restarts the streak
      send(4'd4);
      send(4'd4);
      send(4'd2);
      send(4'd4);
      send(4'd4);
      check1("t2_no_early_commit", out_valid, 1'b0);
      send(4'd4);
      check1("t2_valid", out_valid, 1'b1);
      check8("t2_class", {4'd0, out_class}, 8'd4);
      idle(1);
      check1("t2_single_commit", out_valid, 1'b0);

      // Full output register: second commit dropped, overflow sticky
      do_reset();
      out_ready = 1'b0;
      send(4'd3);
      send(4'd3);
      send(4'd3);
      check1("t3_valid3", out_valid, 1'b1);
      send(4'd5);
      send(4'd5);
      send(4'd5);
      check1("t3_still_valid", out_valid, 1'b1);
      check8("t3_class_stays3", {4'd0, out_class}, 8'd3);
      check1("t3_overflow", overflow, 1'b1);
      out_ready = 1'b1;
      idle(1);
      check1("t3_cleared", out_valid, 1'b0);
      send(4'd5);
      idle(2);
      check1("t3_5_never", out_valid, 1'b0);
      check1("t3_overflow_sticky", overflow, 1'b1);

      // Accept and commit on the same edge: no bubble
      do_reset();
      out_ready = 1'b0;
      send(4'd6);
      send(4'd6);
      send(4'd6);
      send(4'd8);
      send(4'd8);
      check8("t4_hold6", {4'd0, out_class}, 8'd6);
      out_ready = 1'b1;
      send(4'd8);
      check1("t4_valid_held", out_valid, 1'b1);
      check8("t4_class8", {4'd0, out_class}, 8'd8);
      check1("t4_no_overflow", overflow, 1'b0);
      idle(1);
      check1("t4_cleared", out_valid, 1'b0);

      // 1,1,12,1: out-of-range breaks the streak; gaps in in_valid do not
      do_reset();
      send(4'd1);
      send(4'd1);
      send(4'd12);
      send(4'd1);
      check1("t5_no_commit", out_valid, 1'b0);
      check8("t5_err_cnt", err_cnt, ERR_EN ? 8'd1 : 8'd0);
      idle(2);
      send(4'd1);
      check1("t5_still_none", out_valid, 1'b0);
      idle(1);
      send(4'd1);
      check1("t5_commit", out_valid, 1'b1);
      check8("t5_class1", {4'd0, out_class}, 8'd1);

      // Reset mid-streak with a pending output
      do_reset();
      out_ready = 1'b0;
      send(4'd2);
      send(4'd2);
      send(4'd2);
      check1("t6_pending", out_valid, 1'b1);
      send(4'd9);
      send(4'd9);
      do_reset();
      send(4'd9);
      check1("t6_after_one", out_valid, 1'b0);
      send(4'd9);
      check1("t6_after_two", out_valid, 1'b0);
      send(4'd9);
      check1("t6_commit", out_valid, 1'b1);
      check8("t6_class9", {4'd0, out_class}, 8'd9);

      // err_cnt saturates at 255
      do_reset();
      for (int i = 0; i < 260; i++) begin
         send(4'hE);
      end
      check8("t7_err_sat", err_cnt, ERR_EN ? 8'hFF : 8'd0);
      check1("t7_no_output", out_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
